// File: rtl/ser_pkg.sv
// Shared types and size helpers for the word serializer.
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  function automatic int ser_beats(input int data_w, input int out_w);
    return data_w / out_w;
  endfunction

  // A single-beat configuration still needs a one-bit counter.
  function automatic int ser_cnt_w(input int data_w, input int out_w);
    int beats;
    beats = data_w / out_w;
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/ser_beat_counter.sv
// Beat index within the word being serialized; clear has priority over inc.
module ser_beat_counter #(
  parameter int BEATS = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             is_last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign is_last = (cnt_q == CNT_W'(BEATS - 1));

endmodule

// File: rtl/word_serializer_64to8.sv
// Serializes one DATA_W word into OUT_W beats over valid/ready, with
// zero-bubble reload of the next word on the last-beat transfer.
module word_serializer_64to8
  import ser_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int OUT_W     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  localparam int BEATS = ser_beats(DATA_W, OUT_W);
  localparam int CNT_W = ser_cnt_w(DATA_W, OUT_W);

  if (DATA_W % OUT_W != 0) begin : g_bad_width
    $error("word_serializer_64to8: DATA_W must be a multiple of OUT_W");
  end

  ser_state_e        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              cnt_clear, cnt_inc, cnt_is_last, xfer;
  logic [CNT_W-1:0]  cnt;

  ser_beat_counter #(
    .BEATS(BEATS),
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .inc    (cnt_inc),
    .cnt    (cnt),
    .is_last(cnt_is_last)
  );

  assign xfer = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    cnt_clear   = 1'b0;
    cnt_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d     = SHIFT;
          shift_d     = in_data;
          out_valid_d = 1'b1;
          out_last_d  = (BEATS == 1);
          cnt_clear   = 1'b1;
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (!cnt_is_last) begin
            shift_d    = (MSB_FIRST != 0) ? (shift_q << OUT_W) : (shift_q >> OUT_W);
            cnt_inc    = 1'b1;
            out_last_d = (int'(cnt) + 2 == BEATS);
          end else if (in_valid) begin
            shift_d     = in_data;
            out_valid_d = 1'b1;
            out_last_d  = (BEATS == 1);
            cnt_clear   = 1'b1;
          end else begin
            state_d     = IDLE;
            shift_d     = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // The registered beat always tracks the head of the next shift value.
    out_data_d = (MSB_FIRST != 0) ? shift_d[DATA_W-1 -: OUT_W] : shift_d[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready  = (state_q == IDLE) | (out_valid_q & out_ready & out_last_q);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_word_serializer_64to8.sv
// Scoreboard bench: an MSB-first and an LSB-first serializer driven in parallel.
module tb_word_serializer_64to8;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  localparam logic [63:0] W1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] W2 = 64'hFEDC_BA98_7654_3210;
  localparam int          N_RAND = 1500;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready_m, out_valid_m, out_last_m, busy_m;
  logic        in_ready_l, out_valid_l, out_last_l, busy_l;
  logic [7:0]  out_data_m, out_data_l;

  beat_t       q_m[$];
  beat_t       q_l[$];
  int          tests = 0;
  int          fails = 0;
  int          beats_m = 0;
  int          beats_l = 0;

  logic [7:0]  exp_m [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
  logic [7:0]  exp_l [8] = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};

  always #5 clk = ~clk;

  word_serializer_64to8 #(.DATA_W(64), .OUT_W(8), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_m), .out_data(out_data_m), .out_valid(out_valid_m),
    .out_ready(out_ready), .out_last(out_last_m), .busy(busy_m)
  );

  word_serializer_64to8 #(.DATA_W(64), .OUT_W(8), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_l), .out_data(out_data_l), .out_valid(out_valid_l),
    .out_ready(out_ready), .out_last(out_last_l), .busy(busy_l)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic scoreboard();
    beat_t e;
    if (out_valid_m && out_ready) begin
      beats_m++;
      if (q_m.size() == 0) checkOutput("m_extra_beat", 1, 0);
      else begin
        e = q_m.pop_front();
        checkOutput("m_beat_data", out_data_m, e.data);
        checkOutput("m_beat_last", out_last_m, e.last);
      end
    end
    if (out_valid_l && out_ready) begin
      beats_l++;
      if (q_l.size() == 0) checkOutput("l_extra_beat", 1, 0);
      else begin
        e = q_l.pop_front();
        checkOutput("l_beat_data", out_data_l, e.data);
        checkOutput("l_beat_last", out_last_l, e.last);
      end
    end
    if (in_valid && in_ready_m)
      for (int k = 0; k < 8; k++) q_m.push_back({in_data[63-8*k -: 8], k == 7});
    if (in_valid && in_ready_l)
      for (int k = 0; k < 8; k++) q_l.push_back({in_data[8*k +: 8], k == 7});
  endtask

  // Drives one cycle's inputs just after the falling edge and scores the handshakes.
  task automatic applyStimulus(input logic v, input logic [63:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    scoreboard();
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic        rv;
  logic [63:0] rd;
  logic        pend;
  int          acc;
  int          snap_m, snap_l;

  initial begin
    #3;
    checkOutput("rst_out_data_m", out_data_m, 0);
    checkOutput("rst_out_data_l", out_data_l, 0);
    checkOutput("rst_out_valid", out_valid_m, 0);
    checkOutput("rst_out_last", out_last_m, 0);
    checkOutput("rst_busy", busy_m, 0);
    checkOutput("rst_in_ready", in_ready_m, 1);
    @(negedge clk);
    reset = 1'b1;
    nextCycle();

    // Single word at full rate
    applyStimulus(1, W1, 1);
    checkOutput("t1_idle_ready", in_ready_m, 1);
    nextCycle();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, '0, 1);
      checkOutput("t1_valid", out_valid_m, 1);
      checkOutput("t1_data_m", out_data_m, exp_m[k]);
      checkOutput("t1_data_l", out_data_l, exp_l[k]);
      checkOutput("t1_last", out_last_m, k == 7);
      checkOutput("t1_in_ready", in_ready_m, k == 7);
      nextCycle();
    end
    applyStimulus(0, '0, 1);
    checkOutput("t1_after_valid", out_valid_m, 0);
    checkOutput("t1_after_ready", in_ready_m, 1);
    checkOutput("t1_after_busy", busy_m, 0);
    nextCycle();

    // Back-to-back words, no bubble
    applyStimulus(1, W1, 1);
    nextCycle();
    for (int k = 0; k < 16; k++) begin
      applyStimulus(k < 8, W2, 1);
      checkOutput("t2_no_gap", out_valid_m, 1);
      checkOutput("t2_in_ready", in_ready_m, (k == 7) || (k == 15));
      if (k == 8) checkOutput("t2_second_first", out_data_m, 8'hFE);
      nextCycle();
    end
    applyStimulus(0, '0, 1);
    checkOutput("t2_idle", out_valid_m, 0);
    nextCycle();

    // Backpressure on the fourth beat
    applyStimulus(1, W1, 1);
    nextCycle();
    for (int c = 0; c < 11; c++) begin
      applyStimulus(0, '0, !(c >= 3 && c <= 5));
      checkOutput("t3_valid", out_valid_m, 1);
      if (c >= 3 && c <= 6) begin
        checkOutput("t3_hold_data", out_data_m, 8'h67);
        checkOutput("t3_hold_last", out_last_m, 0);
      end
      nextCycle();
    end
    applyStimulus(0, '0, 1);
    checkOutput("t3_idle", out_valid_m, 0);
    nextCycle();

    // Reset after the third beat discards the word
    applyStimulus(1, W1, 1);
    nextCycle();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, '0, 1);
      nextCycle();
    end
    reset = 1'b0;
    #1;
    checkOutput("t4_data", out_data_m, 0);
    checkOutput("t4_valid", out_valid_m, 0);
    checkOutput("t4_last", out_last_m, 0);
    checkOutput("t4_busy", busy_m, 0);
    checkOutput("t4_in_ready", in_ready_m, 1);
    q_m.delete();
    q_l.delete();
    nextCycle();
    reset = 1'b1;
    applyStimulus(1, W2, 1);
    nextCycle();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, '0, 1);
      if (k == 0) begin
        checkOutput("t4_first_m", out_data_m, 8'hFE);
        checkOutput("t4_first_l", out_data_l, 8'h10);
      end
      nextCycle();
    end

    // Random valid/ready traffic
    snap_m = beats_m;
    snap_l = beats_l;
    acc    = 0;
    pend   = 1'b0;
    rv     = 1'b0;
    rd     = '0;
    for (int c = 0; c < 60000 && acc < N_RAND; c++) begin
      if (!pend) begin
        rv = ($urandom_range(0, 9) < 7);
        rd = {$urandom, $urandom};
      end
      applyStimulus(rv, rd, $urandom_range(0, 3) != 0);
      if (rv && in_ready_m) begin
        acc++;
        pend = 1'b0;
      end else begin
        pend = rv;
      end
      nextCycle();
    end
    checkOutput("rand_words", acc, N_RAND);
    for (int c = 0; c < 200 && (q_m.size() != 0 || q_l.size() != 0); c++) begin
      applyStimulus(0, '0, 1);
      nextCycle();
    end
    checkOutput("drain_m_empty", q_m.size(), 0);
    checkOutput("drain_l_empty", q_l.size(), 0);
    checkOutput("rand_beats_m", beats_m - snap_m, N_RAND * 8);
    checkOutput("rand_beats_l", beats_l - snap_l, N_RAND * 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
